// File: rtl/egd_pkg.sv
// egd_pkg: shared constants and types for the bitstream ingress path.
//   - Default bitstream word width and FIFO depth.
//   - LA bit positions used by the wrapper to map LA lines onto this block.
//   - FIFO pointer type: one extra MSB distinguishes full from empty.
package egd_pkg;

  localparam int EGD_BS_W     = 16;
  localparam int EGD_BS_DEPTH = 8;
  localparam int EGD_BS_AW    = $clog2(EGD_BS_DEPTH);

  // LA bit map (CPU -> block)
  localparam int LA_WDATA_LSB = 32;
  localparam int LA_WDATA_MSB = 47;
  localparam int LA_WR_TGL    = 48;
  localparam int LA_FLUSH     = 49;

  // LA bit map (block -> CPU)
  localparam int LA_ACK       = 16;
  localparam int LA_FULL      = 17;
  localparam int LA_OVF       = 18;
  localparam int LA_LEVEL_LSB = 19;
  localparam int LA_LEVEL_MSB = 22;

  typedef logic [EGD_BS_AW:0] egd_ptr_t;

endpackage

// File: rtl/egd_sync2.sv
// egd_sync2: two-flop single-bit synchronizer, async active-low reset.
//   clk_i   - destination clock
//   rst_n_i - async reset, active low (both flops clear to 0)
//   d_i     - asynchronous input bit
//   q_o     - synchronized output (second flop)
module egd_sync2 (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s2_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/egd_bs_ingress.sv
// egd_bs_ingress: LA-driven bitstream ingress FIFO feeding the H.264 core.
//   wb_clk_i, wb_rst_n_i  - clock, async active-low reset
//   la_oenb_i             - 1 = ignore LA write/flush lines
//   la_wdata_i            - word, stable from toggle until ack
//   la_wr_tgl_i           - each level change requests one write
//   la_flush_i            - level flush request
//   la_ack_tgl_o          - flips once per consumed request
//   la_full_o, la_level_o - FIFO full flag and fill level (0..DEPTH)
//   la_ovf_o              - sticky: a word was dropped on full
//   dec_data_o/valid_o/ready_i - first-word-fall-through decoder port
module egd_bs_ingress
  import egd_pkg::*;
#(
  parameter int DATA_W = EGD_BS_W,
  parameter int DEPTH  = EGD_BS_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              la_oenb_i,
  input  logic [DATA_W-1:0] la_wdata_i,
  input  logic              la_wr_tgl_i,
  input  logic              la_flush_i,
  output logic              la_ack_tgl_o,
  output logic              la_full_o,
  output logic [ADDR_W:0]   la_level_o,
  output logic              la_ovf_o,
  output logic [DATA_W-1:0] dec_data_o,
  output logic              dec_valid_o,
  input  logic              dec_ready_i
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic wr_s2, flush_s2;

  egd_sync2 u_sync_wr (
    .clk_i  (wb_clk_i),
    .rst_n_i(wb_rst_n_i),
    .d_i    (la_wr_tgl_i),
    .q_o    (wr_s2)
  );

  egd_sync2 u_sync_flush (
    .clk_i  (wb_clk_i),
    .rst_n_i(wb_rst_n_i),
    .d_i    (la_flush_i),
    .q_o    (flush_s2)
  );

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            t_prev_q;
  logic            ack_q, ack_d;
  logic            ovf_q, ovf_d;
  logic            push;

  logic pending, flush_act, empty, full, pop;

  // t_prev follows s2 even while the LA is disowned, so toggles seen
  // with la_oenb_i high are swallowed rather than replayed later.
  assign pending   = (wr_s2 != t_prev_q) && !la_oenb_i;
  assign flush_act = flush_s2 && !la_oenb_i;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Valid is masked during flush so no word is popped while pointers clear.
  assign dec_valid_o = !empty && !flush_act;
  assign dec_data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign pop         = dec_valid_o && dec_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    ack_d    = ack_q;
    push     = 1'b0;
    if (pending) ack_d = ~ack_q;
    if (flush_act) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (pending) begin
        // A pop in the same cycle frees the slot the push needs.
        if (full && !pop) begin
          ovf_d = 1'b1;
        end else begin
          push     = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      t_prev_q <= 1'b0;
      ack_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      t_prev_q <= wr_s2;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ack_q    <= ack_d;
      ovf_q    <= ovf_d;
      if (push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= la_wdata_i;
    end
  end

  assign la_ack_tgl_o = ack_q;
  assign la_ovf_o     = ovf_q;
  assign la_full_o    = full;
  assign la_level_o   = wr_ptr_q - rd_ptr_q;

endmodule
